// File: rtl/switch_tick_gen_if.sv
// Push-button and timing strobes for the countdown timer input stage.
// The slave side is the conditioning block; fsm_state exposes its debounce state.
interface switch_tick_gen_if;
   logic       btn_raw;
   logic       SwitchOp;
   logic       SecTimer;
   logic       btn_level;
   logic [1:0] fsm_state;

   modport master (
      output btn_raw,
      input  SwitchOp,
      input  SecTimer,
      input  btn_level,
      input  fsm_state
   );

   modport slave (
      input  btn_raw,
      output SwitchOp,
      output SecTimer,
      output btn_level,
      output fsm_state
   );
endinterface

// File: rtl/switch_tick_gen.sv
// Synchronizes and debounces the operator button into a one-cycle SwitchOp
// pulse, and divides the clock into a one-cycle-per-second SecTimer strobe.
module switch_tick_gen #(
   parameter int TICK_DIV        = 50_000_000,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic              clk,
   input  logic              reset,
   switch_tick_gen_if.slave  bus
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [TW-1:0] tick_cnt;
   logic          sync_meta, sync_out;
   logic          switch_op, sec_timer, btn_level;
   logic          press;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= 1'b0;
         sync_out  <= 1'b0;
      end else begin
         sync_meta <= bus.btn_raw;
         sync_out  <= sync_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE_LOW;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A WAIT state completes after DEBOUNCE_CYCLES further matching samples;
   // any opposite sample drops back to the stable state it came from.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE_LOW: begin
            if (sync_out) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = '0;
            end
         end
         WAIT_HIGH: begin
            if (!sync_out)            state_nxt = IDLE_LOW;
            else if (cnt == CNT_LAST) state_nxt = HIGH;
            else                      cnt_nxt   = cnt + CW'(1);
         end
         HIGH: begin
            if (!sync_out) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = '0;
            end
         end
         WAIT_LOW: begin
            if (sync_out)             state_nxt = HIGH;
            else if (cnt == CNT_LAST) state_nxt = IDLE_LOW;
            else                      cnt_nxt   = cnt + CW'(1);
         end
         default: begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   assign press = (state == WAIT_HIGH) && (state_nxt == HIGH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         switch_op <= 1'b0;
         btn_level <= 1'b0;
      end else begin
         switch_op <= press;
         btn_level <= (state_nxt == HIGH) || (state_nxt == WAIT_LOW);
      end
   end

   // An accepted press re-phases the divider and wins over a terminal count.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tick_cnt  <= '0;
         sec_timer <= 1'b0;
      end else if (press) begin
         tick_cnt  <= '0;
         sec_timer <= 1'b0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt  <= '0;
         sec_timer <= 1'b1;
      end else begin
         tick_cnt  <= tick_cnt + TW'(1);
         sec_timer <= 1'b0;
      end
   end

   assign bus.SwitchOp  = switch_op;
   assign bus.SecTimer  = sec_timer;
   assign bus.btn_level = btn_level;
   assign bus.fsm_state = state;

endmodule
